// File: rtl/backend_dispatch_router_pkg.sv
// Shared types and default sizing for the backend dispatch router.
// Entry and icon widths derive from the packed structs below.
package backend_dispatch_router_pkg;

   localparam int NUM_PARALLEL_INSTR_DISPATCHES = 2;
   localparam int LOG2_NUM_EXEC_UNITS = 2;
   localparam int LOG2_NUM_ICON_CHANNELS = 2;

   typedef struct packed {
      logic [7:0]  opcode;
      logic [5:0]  rd;
      logic [5:0]  rs1;
      logic [5:0]  rs2;
      logic [5:0]  rob_tag;
      logic [31:0] imm;
   } type_iqueue_entry;

   typedef struct packed {
      logic [7:0]  opcode;
      logic [7:0]  dest;
      logic [15:0] payload;
   } type_icon_instr;

   typedef enum logic [1:0] {
      SKID_EMPTY,
      SKID_ONE,
      SKID_TWO
   } skid_state_e;

endpackage

// File: rtl/backend_dispatch_router_eu_fifo.sv
// Per-EU FIFO: NW compacted write ports, one read port, free count.
// Enabled write ports form a prefix; port p lands at wr_ptr + p.
module backend_dispatch_router_eu_fifo
   import backend_dispatch_router_pkg::*;
#(
   parameter int NW    = 2,
   parameter int W     = 64,
   parameter int DEPTH = 4,
   localparam int CW   = $clog2(DEPTH + 1)
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [NW-1:0]   wr_en,
   input  logic [NW*W-1:0] wr_data,
   input  logic            rd_en,
   output logic [W-1:0]    rd_data,
   output logic            valid,
   output logic [CW-1:0]   free
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [W-1:0]  mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [CW-1:0] count;
   logic [PW-1:0] waddr [NW];
   logic          pop;
   int            nwr;

   // Modulo advance; DEPTH need not be a power of two.
   function automatic logic [PW-1:0] adv(input logic [PW-1:0] p,
                                         input int n);
      int t;
      t = int'(p) + n;
      if (t >= DEPTH) t = t - DEPTH;
      return PW'(t);
   endfunction

   assign valid   = (count != '0);
   assign pop     = rd_en & valid;
   assign free    = CW'(DEPTH) - count;
   assign rd_data = mem[rd_ptr];

   always_comb begin
      nwr = 0;
      for (int p = 0; p < NW; p++) begin
         waddr[p] = adv(wr_ptr, p);
         if (wr_en[p]) nwr = nwr + 1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         wr_ptr <= adv(wr_ptr, nwr);
         rd_ptr <= adv(rd_ptr, pop ? 1 : 0);
         count  <= CW'(int'(count) + nwr - (pop ? 1 : 0));
      end
   end

   always_ff @(posedge clk) begin
      for (int p = 0; p < NW; p++) begin
         if (wr_en[p]) mem[waddr[p]] <= wr_data[p*W +: W];
      end
   end

   a_count_bound : assert property (
      @(posedge clk) disable iff (reset) count <= CW'(DEPTH)
   );

endmodule

// File: rtl/backend_dispatch_router.sv
// Routes dispatch groups into per-EU FIFOs and passes interconnect
// instructions through per-channel two-entry skid buffers.
module backend_dispatch_router
   import backend_dispatch_router_pkg::*;
#(
   parameter int NUM_DISPATCH = NUM_PARALLEL_INSTR_DISPATCHES,
   parameter int NUM_EU       = 1 << LOG2_NUM_EXEC_UNITS,
   parameter int ENTRY_W      = $bits(type_iqueue_entry),
   parameter int BUF_DEPTH    = 4,
   parameter int NUM_ICON_CH  = 1 << LOG2_NUM_ICON_CHANNELS,
   parameter int ICON_W       = $bits(type_icon_instr),
   localparam int LOG2_NUM_EU = (NUM_EU > 1) ? $clog2(NUM_EU) : 1
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic [NUM_DISPATCH*ENTRY_W-1:0] disp_entry_i,
   input  logic [NUM_DISPATCH-1:0]         disp_valid_i,
   input  logic [NUM_DISPATCH*LOG2_NUM_EU-1:0] disp_euidx_i,
   output logic                            disp_ready_o,
   output logic [NUM_EU*ENTRY_W-1:0]       eu_entry_o,
   output logic [NUM_EU-1:0]               eu_valid_o,
   input  logic [NUM_EU-1:0]               eu_ready_i,
   input  logic [NUM_ICON_CH*ICON_W-1:0]   icon_instr_i,
   input  logic [NUM_ICON_CH-1:0]          icon_valid_i,
   output logic [NUM_ICON_CH-1:0]          icon_ready_o,
   output logic [NUM_ICON_CH*ICON_W-1:0]   icon_instr_o,
   output logic [NUM_ICON_CH-1:0]          icon_valid_o,
   input  logic [NUM_ICON_CH-1:0]          icon_ready_i,
   output logic                            err_badidx_o
);

   localparam int CW = $clog2(BUF_DEPTH + 1);

   if (BUF_DEPTH < NUM_DISPATCH) begin : g_depth_chk
      $error("BUF_DEPTH must be >= NUM_DISPATCH");
   end

   logic                                         fire;
   logic                                         bad;
   logic                                         err_q;
   logic [NUM_EU-1:0]                            room;
   logic [NUM_EU-1:0][CW-1:0]                    free;
   logic [NUM_EU-1:0][NUM_DISPATCH-1:0]          wen;
   logic [NUM_EU-1:0][NUM_DISPATCH*ENTRY_W-1:0]  wdat;
   int                                           k;

   // Ready depends only on registered FIFO counts.
   assign disp_ready_o = &room;
   assign fire         = disp_ready_o & (|disp_valid_i);
   assign err_badidx_o = err_q;

   always_comb begin
      wen  = '0;
      wdat = '0;
      bad  = 1'b0;
      k    = 0;
      for (int e = 0; e < NUM_EU; e++) begin
         k = 0;
         for (int s = 0; s < NUM_DISPATCH; s++) begin
            if (fire && disp_valid_i[s] &&
                int'(disp_euidx_i[s*LOG2_NUM_EU +: LOG2_NUM_EU]) == e) begin
               for (int p = 0; p < NUM_DISPATCH; p++) begin
                  if (k == p) begin
                     wen[e][p] = 1'b1;
                     wdat[e][p*ENTRY_W +: ENTRY_W] =
                        disp_entry_i[s*ENTRY_W +: ENTRY_W];
                  end
               end
               k = k + 1;
            end
         end
      end
      for (int s = 0; s < NUM_DISPATCH; s++) begin
         if (fire && disp_valid_i[s] &&
             int'(disp_euidx_i[s*LOG2_NUM_EU +: LOG2_NUM_EU]) >= NUM_EU)
            bad = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)    err_q <= 1'b0;
      else if (bad) err_q <= 1'b1;
   end

   for (genvar e = 0; e < NUM_EU; e++) begin : g_eu
      backend_dispatch_router_eu_fifo #(
         .NW    (NUM_DISPATCH),
         .W     (ENTRY_W),
         .DEPTH (BUF_DEPTH)
      ) u_fifo (
         .clk     (clk),
         .reset   (reset),
         .wr_en   (wen[e]),
         .wr_data (wdat[e]),
         .rd_en   (eu_ready_i[e]),
         .rd_data (eu_entry_o[e*ENTRY_W +: ENTRY_W]),
         .valid   (eu_valid_o[e]),
         .free    (free[e])
      );
      assign room[e] = (free[e] >= CW'(NUM_DISPATCH));
   end

   for (genvar c = 0; c < NUM_ICON_CH; c++) begin : g_icon
      skid_state_e       state;
      skid_state_e       state_nxt;
      logic [ICON_W-1:0] d0;
      logic [ICON_W-1:0] d1;
      logic              in_hs;
      logic              out_hs;
      logic              ld0_in;
      logic              ld0_d1;
      logic              ld1;

      assign icon_ready_o[c] = (state != SKID_TWO);
      assign icon_valid_o[c] = (state != SKID_EMPTY);
      assign icon_instr_o[c*ICON_W +: ICON_W] = d0;
      assign in_hs  = icon_valid_i[c] & icon_ready_o[c];
      assign out_hs = icon_valid_o[c] & icon_ready_i[c];

      always_ff @(posedge clk or posedge reset) begin
         if (reset) state <= SKID_EMPTY;
         else       state <= state_nxt;
      end

      always_comb begin
         state_nxt = state;
         ld0_in    = 1'b0;
         ld0_d1    = 1'b0;
         ld1       = 1'b0;
         unique case (state)
            SKID_EMPTY: begin
               if (in_hs) begin
                  state_nxt = SKID_ONE;
                  ld0_in    = 1'b1;
               end
            end
            SKID_ONE: begin
               if (in_hs && out_hs) begin
                  ld0_in = 1'b1;
               end else if (in_hs) begin
                  state_nxt = SKID_TWO;
                  ld1       = 1'b1;
               end else if (out_hs) begin
                  state_nxt = SKID_EMPTY;
               end
            end
            SKID_TWO: begin
               if (out_hs) begin
                  state_nxt = SKID_ONE;
                  ld0_d1    = 1'b1;
               end
            end
            default: state_nxt = SKID_EMPTY;
         endcase
      end

      always_ff @(posedge clk) begin
         if (ld0_in)      d0 <= icon_instr_i[c*ICON_W +: ICON_W];
         else if (ld0_d1) d0 <= d1;
         if (ld1)         d1 <= icon_instr_i[c*ICON_W +: ICON_W];
      end
   end

endmodule

// File: tb/tb_backend_dispatch_router.sv
// Scoreboard bench for backend_dispatch_router: default instance plus
// a NUM_EU=3 / BUF_DEPTH=5 instance for bad-index and odd-depth wrap.
module tb_backend_dispatch_router;

   localparam int EW = 64;
   localparam int IW = 32;

   logic clk = 1'b0;
   logic reset;

   logic [2*EW-1:0] disp_entry;
   logic [1:0]      disp_valid;
   logic [3:0]      disp_euidx;
   logic            disp_ready;
   logic [4*EW-1:0] eu_entry;
   logic [3:0]      eu_valid;
   logic [3:0]      eu_ready;
   logic [4*IW-1:0] icon_in;
   logic [4*IW-1:0] icon_out;
   logic [3:0]      icon_vin;
   logic [3:0]      icon_rout;
   logic [3:0]      icon_vout;
   logic [3:0]      icon_rin;
   logic            err;

   logic [2*EW-1:0] b_entry;
   logic [1:0]      b_valid;
   logic [3:0]      b_euidx;
   logic            b_ready;
   logic [3*EW-1:0] b_eu_entry;
   logic [2:0]      b_eu_valid;
   logic [2:0]      b_eu_ready;
   logic [4*IW-1:0] b_icon_in;
   logic [4*IW-1:0] b_icon_out;
   logic [3:0]      b_icon_vin;
   logic [3:0]      b_icon_rout;
   logic [3:0]      b_icon_vout;
   logic [3:0]      b_icon_rin;
   logic            b_err;

   logic [EW-1:0] exp_a [4][$];
   logic [EW-1:0] exp_b [3][$];
   logic [IW-1:0] exp_icon [$];
   int occ;
   int total;
   int bad;

   always #5 clk = ~clk;

   backend_dispatch_router u_dut (
      .clk          (clk),
      .reset        (reset),
      .disp_entry_i (disp_entry),
      .disp_valid_i (disp_valid),
      .disp_euidx_i (disp_euidx),
      .disp_ready_o (disp_ready),
      .eu_entry_o   (eu_entry),
      .eu_valid_o   (eu_valid),
      .eu_ready_i   (eu_ready),
      .icon_instr_i (icon_in),
      .icon_valid_i (icon_vin),
      .icon_ready_o (icon_rout),
      .icon_instr_o (icon_out),
      .icon_valid_o (icon_vout),
      .icon_ready_i (icon_rin),
      .err_badidx_o (err)
   );

   backend_dispatch_router #(
      .NUM_EU    (3),
      .BUF_DEPTH (5)
   ) u_dut3 (
      .clk          (clk),
      .reset        (reset),
      .disp_entry_i (b_entry),
      .disp_valid_i (b_valid),
      .disp_euidx_i (b_euidx),
      .disp_ready_o (b_ready),
      .eu_entry_o   (b_eu_entry),
      .eu_valid_o   (b_eu_valid),
      .eu_ready_i   (b_eu_ready),
      .icon_instr_i (b_icon_in),
      .icon_valid_i (b_icon_vin),
      .icon_ready_o (b_icon_rout),
      .icon_instr_o (b_icon_out),
      .icon_valid_o (b_icon_vout),
      .icon_ready_i (b_icon_rin),
      .err_badidx_o (b_err)
   );

   task automatic check(input string nm, input logic [63:0] act,
                        input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Monitor: compares every output handshake against the queues.
   always @(negedge clk) begin
      if (!reset) begin
         for (int e = 0; e < 4; e++) begin
            if (eu_valid[e] && eu_ready[e]) begin
               if (exp_a[e].size() == 0)
                  check("eu_a_unexpected", 64'(eu_valid[e]), 0);
               else
                  check("eu_a_data", eu_entry[e*EW +: EW],
                        exp_a[e].pop_front());
            end
         end
         for (int e = 0; e < 3; e++) begin
            if (b_eu_valid[e] && b_eu_ready[e]) begin
               if (exp_b[e].size() == 0)
                  check("eu_b_unexpected", 64'(b_eu_valid[e]), 0);
               else
                  check("eu_b_data", b_eu_entry[e*EW +: EW],
                        exp_b[e].pop_front());
            end
         end
         check("icon_ready", 64'(icon_rout[0]), 64'(occ != 2));
         check("icon_valid", 64'(icon_vout[0]), 64'(occ != 0));
         if (icon_vout[0] && icon_rin[0]) begin
            if (exp_icon.size() == 0)
               check("icon_unexpected", 64'(icon_vout[0]), 0);
            else
               check("icon_data", 64'(icon_out[IW-1:0]),
                     64'(exp_icon.pop_front()));
            occ--;
         end
         if (icon_vin[0] && icon_rout[0]) begin
            exp_icon.push_back(icon_in[IW-1:0]);
            occ++;
         end
      end
   end

   task automatic issue_a(input logic [1:0] v, input logic [1:0] e0,
                          input logic [1:0] e1, input logic [63:0] d0,
                          input logic [63:0] d1);
      int n = 0;
      while (!disp_ready && n < 50) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (!disp_ready) begin
         check("issue_a_timeout", 64'(disp_ready), 1);
      end else begin
         disp_valid = v;
         disp_euidx = {e1, e0};
         disp_entry = {d1, d0};
         if (v[0]) exp_a[e0].push_back(d0);
         if (v[1]) exp_a[e1].push_back(d1);
         @(posedge clk);
         #1;
         disp_valid = '0;
      end
   endtask

   task automatic issue_b(input logic [1:0] v, input logic [1:0] e0,
                          input logic [1:0] e1, input logic [63:0] d0,
                          input logic [63:0] d1);
      int n = 0;
      while (!b_ready && n < 50) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (!b_ready) begin
         check("issue_b_timeout", 64'(b_ready), 1);
      end else begin
         b_valid = v;
         b_euidx = {e1, e0};
         b_entry = {d1, d0};
         if (v[0] && e0 < 3) exp_b[e0].push_back(d0);
         if (v[1] && e1 < 3) exp_b[e1].push_back(d1);
         @(posedge clk);
         #1;
         b_valid = '0;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      total = 0;
      bad = 0;
      occ = 0;
      reset = 1'b1;
      disp_entry = '0;
      disp_valid = '0;
      disp_euidx = '0;
      eu_ready = 4'hF;
      icon_in = '0;
      icon_vin = '0;
      icon_rin = 4'hF;
      b_entry = '0;
      b_valid = '0;
      b_euidx = '0;
      b_eu_ready = 3'h7;
      b_icon_in = '0;
      b_icon_vin = '0;
      b_icon_rin = 4'hF;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;

      check("rst_eu_valid", 64'(eu_valid), 0);
      check("rst_icon_valid", 64'(icon_vout), 0);
      check("rst_icon_ready", 64'(icon_rout), 64'hF);
      check("rst_disp_ready", 64'(disp_ready), 1);
      check("rst_err", 64'(err), 0);
      check("rst_b_ready", 64'(b_ready), 1);

      // single slot to EU2
      issue_a(2'b01, 2'd2, 2'd0, 64'hA5, 64'h0);
      check("t1_valid_next", 64'(eu_valid), 64'b0100);
      @(posedge clk);
      #1;
      check("t1_valid_gone", 64'(eu_valid), 0);

      // both slots to EU1
      issue_a(2'b11, 2'd1, 2'd1, 64'h11, 64'h22);
      check("t2_valid_c1", 64'(eu_valid), 64'b0010);
      @(posedge clk);
      #1;
      check("t2_valid_c2", 64'(eu_valid), 64'b0010);
      @(posedge clk);
      #1;
      check("t2_valid_c3", 64'(eu_valid), 0);

      // EU3 backpressure
      eu_ready = 4'h7;
      issue_a(2'b11, 2'd3, 2'd3, 64'h31, 64'h32);
      issue_a(2'b11, 2'd3, 2'd3, 64'h33, 64'h34);
      check("t3_full_ready", 64'(disp_ready), 0);
      check("t3_full_valid", 64'(eu_valid), 64'b1000);
      disp_valid = 2'b11;
      disp_euidx = {2'd3, 2'd3};
      disp_entry = {64'h36, 64'h35};
      eu_ready = 4'hF;
      @(posedge clk);
      #1;
      check("t3_after_pop1", 64'(disp_ready), 0);
      @(posedge clk);
      #1;
      check("t3_after_pop2", 64'(disp_ready), 1);
      exp_a[3].push_back(64'h35);
      exp_a[3].push_back(64'h36);
      @(posedge clk);
      #1;
      disp_valid = '0;
      repeat (6) @(posedge clk);
      #1;

      // EU0 on depth-5 instance: steady push+pop at count 3
      b_eu_ready = 3'b110;
      issue_b(2'b11, 2'd0, 2'd0, 64'h400, 64'h401);
      issue_b(2'b01, 2'd0, 2'd0, 64'h402, 64'h0);
      check("t4_ready_at3", 64'(b_ready), 1);
      b_eu_ready = 3'h7;
      for (int i = 0; i < 20; i++) begin
         b_valid = 2'b01;
         b_euidx = {2'd0, 2'd0};
         b_entry = {64'h0, 64'h403 + 64'(i)};
         exp_b[0].push_back(64'h403 + 64'(i));
         @(posedge clk);
         #1;
         check("t4_steady_ready", 64'(b_ready), 1);
         check("t4_steady_valid", 64'(b_eu_valid), 64'b001);
      end
      b_valid = '0;
      repeat (6) @(posedge clk);
      #1;

      // bad EU index on the 3-EU instance
      issue_b(2'b11, 2'd3, 2'd1, 64'hBAD, 64'h51);
      check("t5_err_set", 64'(b_err), 1);
      check("t5_other_err", 64'(err), 0);
      check("t5_valid", 64'(b_eu_valid), 64'b010);
      repeat (5) @(posedge clk);
      #1;
      check("t5_err_sticky", 64'(b_err), 1);

      // icon channel 0 burst with reset in the middle
      for (int i = 0; i < 16; i++) begin
         icon_vin = 4'b0001;
         icon_in[IW-1:0] = 32'hC000_0000 + 32'(i);
         icon_rin = {3'b111, (i % 2 == 0)};
         if (i == 9) begin
            reset = 1'b1;
            #1;
            check("t6_rst_icon_valid", 64'(icon_vout), 0);
            check("t6_rst_icon_ready", 64'(icon_rout), 64'hF);
            check("t6_rst_b_err", 64'(b_err), 0);
            check("t6_rst_disp_ready", 64'(disp_ready), 1);
            exp_icon.delete();
            occ = 0;
            @(posedge clk);
            #1;
            reset = 1'b0;
         end else begin
            @(posedge clk);
            #1;
         end
      end
      check("t6_other_ch_idle", 64'(icon_vout[3:1]), 0);
      icon_vin = '0;
      icon_rin = 4'hF;
      repeat (5) @(posedge clk);
      #1;

      for (int e = 0; e < 4; e++)
         check("drain_a", 64'(exp_a[e].size()), 0);
      for (int e = 0; e < 3; e++)
         check("drain_b", 64'(exp_b[e].size()), 0);
      check("drain_icon", 64'(exp_icon.size()), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
